// File: rtl/vga_fb_reader.sv
// Shadow 160x120x3 framebuffer fed by the plot stream, read back in raster order over valid/ready.
// Optional macro FB_CLEAR_EN: zero the whole store after reset before accepting plots or scans.
module vga_fb_reader (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] vga_x,
  input  logic [6:0] vga_y,
  input  logic [2:0] vga_colour,
  input  logic       vga_plot,
  input  logic       start,
  input  logic       pix_ready,
  output logic       pix_valid,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic [2:0] pix_colour,
  output logic       sof,
  output logic       eol,
  output logic       busy,
  output logic       done,
  output logic [7:0] drop_cnt
);

  localparam int W = 160;
  localparam int H = 120;
  localparam int DEPTH = W * H;
  localparam logic [7:0]  X_LIM     = 8'(W);
  localparam logic [6:0]  Y_LIM     = 7'(H);
  localparam logic [7:0]  X_LAST    = 8'(W - 1);
  localparam logic [6:0]  Y_LAST    = 7'(H - 1);
  localparam logic [14:0] ADDR_LAST = 15'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, FETCH, PRESENT, DONE, CLEAR} state_t;

`ifdef FB_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t      state, state_next;
  logic [2:0]  mem [DEPTH];
  logic [2:0]  rd_data;
  logic [7:0]  scan_x;
  logic [6:0]  scan_y;
  logic [14:0] clear_addr;
  logic [14:0] rd_addr, wr_addr;
  logic [2:0]  wr_data;
  logic        rd_en, clearing, scan_last, handshake;
  logic        plot_in_range, mem_we, drop_en;

  // y*160 + x without a multiplier: 160 = 128 + 32
  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    logic [14:0] yw;
    yw = {8'd0, y};
    return (yw << 7) + (yw << 5) + {7'd0, x};
  endfunction

  assign plot_in_range = (vga_x < X_LIM) && (vga_y < Y_LIM);
  assign drop_en       = vga_plot && !plot_in_range && !clearing;
  assign mem_we        = clearing || (vga_plot && plot_in_range);
  assign wr_addr       = clearing ? clear_addr : pix_addr(vga_x, vga_y);
  assign wr_data       = clearing ? 3'd0 : vga_colour;
  assign rd_addr       = pix_addr(scan_x, scan_y);
  assign scan_last     = (scan_x == X_LAST) && (scan_y == Y_LAST);
  assign handshake     = pix_valid && pix_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = PRESENT;
      PRESENT: if (pix_ready) state_next = scan_last ? DONE : FETCH;
      DONE:    state_next = IDLE;
      CLEAR:   if (clear_addr == ADDR_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pix_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    clearing  = 1'b0;
    unique case (state)
      IDLE:    busy      = 1'b0;
      FETCH:   rd_en     = 1'b1;
      PRESENT: pix_valid = 1'b1;
      DONE:    done      = 1'b1;
      CLEAR:   clearing  = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_x <= '0;
      scan_y <= '0;
    end else if (state == IDLE && start) begin
      scan_x <= '0;
      scan_y <= '0;
    end else if (handshake && !scan_last) begin
      if (scan_x == X_LAST) begin
        scan_x <= '0;
        scan_y <= scan_y + 7'd1;
      end else begin
        scan_x <= scan_x + 8'd1;
      end
    end
  end

`ifdef FB_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   clear_addr <= '0;
    else if (clearing && clear_addr != ADDR_LAST) clear_addr <= clear_addr + 15'd1;
  end
`else
  assign clear_addr = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             drop_cnt <= '0;
    else if (drop_en && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  // Read and write in separate processes so a same-address collision reads the old value
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  assign pix_x      = pix_valid ? scan_x  : '0;
  assign pix_y      = pix_valid ? scan_y  : '0;
  assign pix_colour = pix_valid ? rd_data : '0;
  assign sof        = pix_valid && (scan_x == 8'd0) && (scan_y == 7'd0);
  assign eol        = pix_valid && (scan_x == X_LAST);

endmodule
